window_gen_3x3: RTL and testbench



---
 rtl/window_gen_3x3.sv | 108 ++++++++++
 tb/tb_window_gen_3x3.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixel stream to registered 3x3 neighbourhood.
// Two line buffers hold the previous two rows. A nine-register window shifts
// left on every accepted pixel.
// Window layout: p1 p2 p3 is the oldest row, p7 p8 p9 is the newest row.
// Optional build macro SOF_SYNC_EN adds a 'sof' input. An accepted pixel that
// carries sof is placed at (0,0) of a new frame.
module window_gen_3x3 #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SOF_SYNC_EN
   input  logic             sof,
`endif
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic [PIX_W-1:0] p1,
   output logic [PIX_W-1:0] p2,
   output logic [PIX_W-1:0] p3,
   output logic [PIX_W-1:0] p4,
   output logic [PIX_W-1:0] p5,
   output logic [PIX_W-1:0] p6,
   output logic [PIX_W-1:0] p7,
   output logic [PIX_W-1:0] p8,
   output logic [PIX_W-1:0] p9,
   output logic             win_valid,
   output logic             win_last
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]    col_cnt;
   logic [RW-1:0]    row_cnt;
   logic [CW-1:0]    x;
   logic             sof_hit;
   logic             col_end;
   logic             row_end;
   logic             interior;
   logic             frame_end;
   logic [PIX_W-1:0] lb0 [IMG_WIDTH];
   logic [PIX_W-1:0] lb1 [IMG_WIDTH];

`ifdef SOF_SYNC_EN
   assign sof_hit = sof & pix_valid;
`else
   assign sof_hit = 1'b0;
`endif

   // A sof pixel is handled as column 0 of row 0, whatever the counters say.
   assign x         = sof_hit ? '0 : col_cnt;
   assign col_end   = (col_cnt == COL_LAST);
   assign row_end   = (row_cnt == ROW_LAST);
   assign interior  = !sof_hit && (col_cnt >= CW'(2)) && (row_cnt >= RW'(2));
   assign frame_end = !sof_hit && col_end && row_end;

   // Position counters: track the raster coordinate of the pixel being accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (pix_valid) begin
         if (sof_hit) begin
            col_cnt <= CW'(1);
            row_cnt <= '0;
         end else if (col_end) begin
            col_cnt <= '0;
            row_cnt <= row_end ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   // Line buffers: rows y-1 and y-2. Old contents are read before they are
   // overwritten. The contents are not reset, because rows 0 and 1 gate
   // win_valid.
   always_ff @(posedge clk) begin
      if (pix_valid && !rst) begin
         lb0[x] <= lb1[x];
         lb1[x] <= pix_in;
      end
   end

   // Window shift register and output qualifiers.
   always_ff @(posedge clk) begin
      if (rst) begin
         p1 <= '0; p2 <= '0; p3 <= '0;
         p4 <= '0; p5 <= '0; p6 <= '0;
         p7 <= '0; p8 <= '0; p9 <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         if (pix_valid) begin
            p1 <= p2; p2 <= p3; p3 <= lb0[x];
            p4 <= p5; p5 <= p6; p6 <= lb1[x];
            p7 <= p8; p8 <= p9; p9 <= pix_in;
         end
         win_valid <= pix_valid && interior;
         win_last  <= pix_valid && frame_end;
      end
   end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 with an 8x6 image. Each pixel value is base + y*16 + x.
// When an interior pixel is driven, the bench pushes the expected window.
// The bench pops and compares that window when win_valid appears.
module tb_window_gen_3x3;

   localparam int W = 8;
   localparam int H = 6;

   typedef struct packed {
      logic [8:0][7:0] p;
      logic            last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0;
`ifdef SOF_SYNC_EN
   logic       sof = 1'b0;
`endif
   logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic       win_valid, win_last;

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .clk(clk), .rst(rst),
`ifdef SOF_SYNC_EN
      .sof(sof),
`endif
      .pix_in(pix_in), .pix_valid(pix_valid),
      .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
      .win_valid(win_valid), .win_last(win_last)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Values the driver attaches to the pixel it is currently presenting.
   logic            cur_int = 1'b0;
   logic            cur_last = 1'b0;
   logic [8:0][7:0] cur_win = '0;

   exp_t            sb[$];
   logic [8:0][7:0] hold_win = '0;
   logic            hold_ok = 1'b0;
   logic            prev_valid = 1'b0;
   logic            prev_rst = 1'b1;
   int              wins = 0;
   int              lasts = 0;
   int              cap_idx = 0;
   logic [7:0]      cap_p1 = '0, cap_p5 = '0, cap_p9 = '0;

   // Record what the DUT accepts on this edge.
   always @(posedge clk) begin
      prev_valid <= pix_valid;
      prev_rst   <= rst;
      if (rst) begin
         hold_ok <= 1'b0;
      end else if (pix_valid) begin
         if (cur_int) begin
            sb.push_back('{p: cur_win, last: cur_last});
            hold_win <= cur_win;
            hold_ok  <= 1'b1;
         end else begin
            hold_ok <= 1'b0;
         end
      end
   end

   // Compare the registered outputs at mid-cycle.
   always @(negedge clk) begin
      logic [7:0] pv [9];
      exp_t e;
      pv = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
      if (win_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_win", 1, 0);
         end else begin
            e = sb.pop_front();
            for (int k = 0; k < 9; k++)
               chk($sformatf("win_p%0d", k + 1), int'(pv[k]), int'(e.p[k]));
            chk("win_last", int'(win_last), int'(e.last));
         end
         if (wins == cap_idx) begin
            cap_p1 = p1; cap_p5 = p5; cap_p9 = p9;
         end
         wins++;
         if (win_last) lasts++;
      end else begin
         chk("last_without_valid", int'(win_last), 0);
      end
      if (!prev_valid && !prev_rst) begin
         chk("gap_valid", int'(win_valid), 0);
         if (hold_ok) begin
            chk("hold_p1", int'(p1), int'(hold_win[0]));
            chk("hold_p5", int'(p5), int'(hold_win[4]));
            chk("hold_p9", int'(p9), int'(hold_win[8]));
         end
      end
   end

   task automatic idle();
      @(posedge clk); #1;
      pix_valid = 1'b0;
      cur_int   = 1'b0;
`ifdef SOF_SYNC_EN
      sof = 1'b0;
`endif
   endtask

   // Drive npix pixels of a frame starting at (0,0). Optional random gaps.
   // The first pixel can carry sof.
   task automatic send_frame(input int base, input bit gaps, input int npix, input bit sof_first);
      int n;
      n = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (n >= npix) return;
            if (gaps) while ($urandom_range(0, 2) != 0) idle();
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_in    = 8'(base + y * 16 + x);
            cur_int   = (x >= 2) && (y >= 2);
            cur_last  = (x == W - 1) && (y == H - 1);
            for (int k = 0; k < 9; k++)
               cur_win[k] = 8'(base + (y - 2 + k / 3) * 16 + (x - 2 + k % 3));
`ifdef SOF_SYNC_EN
            sof = sof_first && (n == 0);
`else
            if (sof_first) $display("note: sof requested but not built in");
`endif
            n++;
         end
      end
   endtask

   task automatic finish_frame(input string tag, input int exp_wins);
      repeat (3) idle();
      chk({tag, "_wins"}, wins, exp_wins);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_p1", int'(p1), 0);
      chk("rst_p5", int'(p5), 0);
      chk("rst_p9", int'(p9), 0);
      chk("rst_valid", int'(win_valid), 0);
      chk("rst_last", int'(win_last), 0);

      // Continuous frame.
      wins = 0; lasts = 0; cap_idx = 0;
      send_frame(0, 1'b0, W * H, 1'b0);
      finish_frame("cont", 24);
      chk("cont_lasts", lasts, 1);
      chk("cont_first_p1", int'(cap_p1), 'h00);
      chk("cont_first_p5", int'(cap_p5), 'h11);
      chk("cont_first_p9", int'(cap_p9), 'h22);

      // The same frame with random idle cycles between pixels.
      wins = 0; lasts = 0;
      send_frame(0, 1'b1, W * H, 1'b0);
      finish_frame("gaps", 24);
      chk("gaps_lasts", lasts, 1);

      // Two frames back to back. The second frame is offset by 0x80.
      wins = 0; lasts = 0; cap_idx = 24;
      send_frame(0, 1'b0, W * H, 1'b0);
      send_frame('h80, 1'b0, W * H, 1'b0);
      finish_frame("b2b", 48);
      chk("b2b_lasts", lasts, 2);
      chk("b2b_second_p1", int'(cap_p1), 'h80);
      chk("b2b_second_p5", int'(cap_p5), 'h91);
      chk("b2b_second_p9", int'(cap_p9), 'hA2);

      // Reset in the middle of a frame, then a fresh frame.
      wins = 0; lasts = 0; cap_idx = 0;
      send_frame('h40, 1'b0, 30, 1'b0);
      @(posedge clk); #1;
      pix_valid = 1'b0; cur_int = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_p5", int'(p5), 0);
      chk("midrst_wins", wins, 10);
      wins = 0; lasts = 0;
      send_frame(0, 1'b0, W * H, 1'b0);
      finish_frame("postrst", 24);
      chk("postrst_first_p5", int'(cap_p5), 'h11);

`ifdef SOF_SYNC_EN
      // Ten unrelated pixels, then a frame whose first pixel carries sof.
      wins = 0; lasts = 0; cap_idx = 0;
      send_frame('h60, 1'b0, 10, 1'b0);
      send_frame(0, 1'b0, W * H, 1'b1);
      finish_frame("sof", 24);
      chk("sof_lasts", lasts, 1);
      chk("sof_first_p5", int'(cap_p5), 'h11);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
